// File: rtl/radiant_trig_pkg.sv
// Shared constants and types for the RADIANT coincidence trigger.
package radiant_trig_pkg;

  localparam int unsigned NCHAN   = 24;
  localparam int unsigned NSTAGE  = 4;
  localparam int unsigned STAGE_W = 5;
  localparam int unsigned THR_W   = 6;
  localparam int unsigned WIN_W   = 7;
  localparam int unsigned CNT_W   = 5;

  typedef logic [WIN_W-1:0] win_t;

  // Sum of the window-length fields; 4 x 31 fits in 7 bits without overflow.
  function automatic win_t win_sum(input logic [NSTAGE*STAGE_W-1:0] fields);
    win_t s;
    s = '0;
    for (int k = 0; k < int'(NSTAGE); k++) begin
      s = s + WIN_W'(fields[k*STAGE_W +: STAGE_W]);
    end
    return s;
  endfunction

endpackage

// File: rtl/radiant_coinc_trigger_if.sv
// Trigger-path signal bundle between the channel front end and the coincidence core.
interface radiant_coinc_trigger_if;
  import radiant_trig_pkg::*;

  logic [NCHAN-1:0]          trig_i;
  logic [NCHAN-1:0]          en_i;
  logic [NSTAGE*STAGE_W-1:0] oneshot_i;
  logic [THR_W-1:0]          threshold_i;
  logic                      trigger_o;

  modport master (
    output trig_i,
    output en_i,
    output oneshot_i,
    output threshold_i,
    input  trigger_o
  );

  modport slave (
    input  trig_i,
    input  en_i,
    input  oneshot_i,
    input  threshold_i,
    output trigger_o
  );

endinterface

// File: rtl/radiant_trig_stretch.sv
// One channel: rising-edge detect, enable gating and window down-counter.
module radiant_trig_stretch
  import radiant_trig_pkg::*;
(
  input  logic trig_clk_i,
  input  logic rst_n_i,
  input  logic trig_i,
  input  logic en_i,
  input  win_t win_i,
  output logic open_o
);

  logic r_trig;
  win_t r_cnt;
  win_t w_cnt_d;
  logic w_edge;

  assign w_edge = trig_i & ~r_trig;

  // A retrigger restarts the full window; a zero window still opens for one cycle.
  always_comb begin
    w_cnt_d = r_cnt;
    if (!en_i) begin
      w_cnt_d = '0;
    end else if (w_edge) begin
      w_cnt_d = (win_i == '0) ? WIN_W'(1) : win_i;
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - WIN_W'(1);
    end
  end

  always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_trig <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_trig <= trig_i;
      r_cnt  <= w_cnt_d;
    end
  end

  assign open_o = (r_cnt != '0);

endmodule

// File: rtl/radiant_coinc_trigger.sv
// Coincidence core: per-channel window stretch, registered popcount and threshold compare.
module radiant_coinc_trigger
  import radiant_trig_pkg::*;
(
  input  logic                           trig_clk_i,
  input  logic                           rst_n_i,
  radiant_coinc_trigger_if.slave         trig_bus
);

  win_t             r_win;
  logic [CNT_W-1:0] r_count;
  logic             r_trigger;
  logic [NCHAN-1:0] w_open;
  logic [CNT_W-1:0] w_pop;

  for (genvar g = 0; g < int'(NCHAN); g++) begin : g_chan
    radiant_trig_stretch u_stretch (
      .trig_clk_i (trig_clk_i),
      .rst_n_i    (rst_n_i),
      .trig_i     (trig_bus.trig_i[g]),
      .en_i       (trig_bus.en_i[g]),
      .win_i      (r_win),
      .open_o     (w_open[g])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(NCHAN); i++) begin
      w_pop = w_pop + CNT_W'(w_open[i]);
    end
  end

  always_ff @(posedge trig_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_win     <= '0;
      r_count   <= '0;
      r_trigger <= 1'b0;
    end else begin
      r_win     <= win_sum(trig_bus.oneshot_i);
      r_count   <= w_pop;
      r_trigger <= (trig_bus.threshold_i != '0) &&
                   ({1'b0, r_count} >= trig_bus.threshold_i);
    end
  end

  assign trig_bus.trigger_o = r_trigger;

endmodule

// File: tb/tb_radiant_coinc_trigger.sv
// Self-checking bench: time-based window model plus directed literal checks and random traffic.
module tb_radiant_coinc_trigger;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  radiant_coinc_trigger_if u_if ();

  radiant_coinc_trigger u_dut (
    .trig_clk_i (clk),
    .rst_n_i    (rst_n),
    .trig_bus   (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit log_hi [0:32767];

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, expv);
    end
  endtask

  // Model: each channel closes at an absolute cycle; open after edge t means t < expire.
  longint expire [24];
  logic [23:0] prev_trig;
  int prev_sum, oc1, oc2, oc_now, eff, thr_v;
  bit exp_trig;

  function automatic int field_sum(input logic [19:0] f);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(f[k*5 +: 5]);
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        prev_trig = '0;
        prev_sum = 0;
        for (int i = 0; i < 24; i++) expire[i] = 0;
        oc1 = 0;
        oc2 = 0;
        exp_trig = 1'b0;
      end else begin
        eff = (prev_sum == 0) ? 1 : prev_sum;
        for (int i = 0; i < 24; i++) begin
          if (!u_if.en_i[i]) expire[i] = cyc;
          else if (u_if.trig_i[i] && !prev_trig[i]) expire[i] = cyc + eff;
        end
        oc_now = 0;
        for (int i = 0; i < 24; i++) if (longint'(cyc) < expire[i]) oc_now++;
        thr_v = int'(u_if.threshold_i);
        exp_trig = (thr_v != 0) && (oc2 >= thr_v);
        oc2 = oc1;
        oc1 = oc_now;
        prev_trig = u_if.trig_i;
        prev_sum = field_sum(u_if.oneshot_i);
      end
      #1;
      log_hi[cyc] = u_if.trigger_o;
      check("model_trigger", int'(u_if.trigger_o), int'(exp_trig));
    end
  end

  function automatic int count_hi(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += int'(log_hi[c]);
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input logic [23:0] en, input logic [5:0] thr, input logic [19:0] os);
    @(negedge clk);
    u_if.trig_i = '0;
    u_if.en_i = en;
    u_if.threshold_i = thr;
    u_if.oneshot_i = os;
    tick(3);
  endtask

  // Two overlaid pulse trains; k is the edge that samples cycle 0 of the sequence.
  task automatic drive_seq(input logic [23:0] ma, input int sa, input int la,
                           input logic [23:0] mb, input int sb, input int lb,
                           input int ncyc, input int en_clr_at, output int k);
    k = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) k = cyc + 1;
      u_if.trig_i = ((c >= sa && c < sa + la) ? ma : 24'h0) |
                    ((c >= sb && c < sb + lb) ? mb : 24'h0);
      if (c == en_clr_at) u_if.en_i[0] = 1'b0;
    end
    @(negedge clk);
    u_if.trig_i = '0;
    tick(2);
  endtask

  localparam logic [19:0] OS39 = {5'd0, 5'd0, 5'd9, 5'd30};
  int k;

  initial begin
    u_if.trig_i = '0;
    u_if.en_i = 24'hFFFFFF;
    u_if.threshold_i = 6'd1;
    u_if.oneshot_i = OS39;

    // Reset held with all channels pulsing.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      u_if.trig_i = (c % 2 == 0) ? 24'hFFFFFF : 24'h0;
      #1 check("reset_hold", int'(u_if.trigger_o), 0);
    end
    @(negedge clk);
    u_if.trig_i = '0;
    rst_n = 1'b1;
    tick(5);
    check("after_release", int'(u_if.trigger_o), 0);

    // Single channel, WIN = 39.
    cfg(24'h000003, 6'd1, OS39);
    drive_seq(24'h1, 0, 2, 24'h0, 0, 0, 60, -1, k);
    check("single_k1", int'(log_hi[k+1]), 0);
    check("single_k2", int'(log_hi[k+2]), 1);
    check("single_k40", int'(log_hi[k+40]), 1);
    check("single_k41", int'(log_hi[k+41]), 0);
    check("single_len", count_hi(k, k + 58), 39);

    // Coincidence, threshold 2.
    cfg(24'h000003, 6'd2, OS39);
    drive_seq(24'h1, 0, 2, 24'h2, 38, 2, 90, -1, k);
    check("coinc_k39", int'(log_hi[k+39]), 0);
    check("coinc_k40", int'(log_hi[k+40]), 1);
    check("coinc_len", count_hi(k, k + 88), 1);
    cfg(24'h000003, 6'd2, OS39);
    drive_seq(24'h1, 0, 2, 24'h2, 39, 2, 90, -1, k);
    check("coinc_miss", count_hi(k, k + 88), 0);

    // Masking.
    cfg(24'h000001, 6'd1, OS39);
    drive_seq(24'hFFFFFE, 0, 2, 24'h0, 0, 0, 50, -1, k);
    check("mask_len", count_hi(k, k + 48), 0);
    cfg(24'h000001, 6'd1, OS39);
    drive_seq(24'h1, 0, 2, 24'h0, 0, 0, 50, 10, k);
    check("mask_clr_k11", int'(log_hi[k+11]), 1);
    check("mask_clr_k12", int'(log_hi[k+12]), 0);
    check("mask_clr_len", count_hi(k, k + 48), 10);

    // Held input and retrigger.
    cfg(24'h000001, 6'd1, OS39);
    drive_seq(24'h1, 0, 100, 24'h0, 0, 0, 110, -1, k);
    check("held_len", count_hi(k, k + 108), 39);
    cfg(24'h000001, 6'd1, OS39);
    drive_seq(24'h1, 0, 2, 24'h1, 20, 2, 80, -1, k);
    check("retrig_k60", int'(log_hi[k+60]), 1);
    check("retrig_k61", int'(log_hi[k+61]), 0);
    check("retrig_len", count_hi(k, k + 78), 59);

    // Threshold and window boundaries.
    cfg(24'hFFFFFF, 6'd0, OS39);
    drive_seq(24'hFFFFFF, 0, 2, 24'h0, 0, 0, 50, -1, k);
    check("thr0_len", count_hi(k, k + 48), 0);
    cfg(24'hFFFFFF, 6'd24, OS39);
    drive_seq(24'hFFFFFF, 0, 2, 24'h0, 0, 0, 50, -1, k);
    check("thr24_len", count_hi(k, k + 48), 39);
    cfg(24'hFFFFFF, 6'd25, OS39);
    drive_seq(24'hFFFFFF, 0, 2, 24'h0, 0, 0, 50, -1, k);
    check("thr25_len", count_hi(k, k + 48), 0);
    cfg(24'h000001, 6'd1, 20'h0);
    drive_seq(24'h1, 0, 2, 24'h0, 0, 0, 10, -1, k);
    check("win0_k2", int'(log_hi[k+2]), 1);
    check("win0_len", count_hi(k, k + 8), 1);
    cfg(24'h000001, 6'd1, 20'hFFFFF);
    drive_seq(24'h1, 0, 2, 24'h0, 0, 0, 140, -1, k);
    check("win124_len", count_hi(k, k + 138), 124);

    // Random traffic against the model, with one mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      u_if.trig_i = 24'($urandom & $urandom & $urandom & $urandom & $urandom);
      if (c % 250 == 0) begin
        u_if.threshold_i = 6'($urandom_range(0, 26));
        u_if.en_i = 24'($urandom | $urandom);
        u_if.oneshot_i = 20'($urandom);
      end
      if (c % 37 == 0) u_if.en_i[$urandom_range(0, 23)] ^= 1'b1;
      if (c == 2000) rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
    end
    @(negedge clk);
    u_if.trig_i = '0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/radiant_coinc_trigger.md
Name: radiant_coinc_trigger

Overview:
- Coincidence trigger core for the RADIANT 24-channel trigger path, single clock domain (trigger clock, 400 MHz nominal).
- Takes per-channel trigger pulses that are already synchronous to the trigger clock (one-shot outputs).
- Stretches each enabled channel into a programmable coincidence window, counts the channels open at once, and asserts trigger_o when the count meets the programmed threshold.

Parameters:
- NCHAN, 24, number of trigger channels
- NSTAGE, 4, number of window-length fields summed to form the window
- STAGE_W, 5, width of each window-length field (clock cycles)
- THR_W, 6, threshold width

Ports:
- trig_clk_i  in  1  trigger clock; all logic on rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- trig_i  in  NCHAN  per-channel trigger pulses, synchronous to trig_clk_i, any length
- en_i  in  NCHAN  per-channel enable mask, quasi-static
- oneshot_i  in  NSTAGE*STAGE_W (20)  window-length fields; field k = bits [5k+4:5k]
- threshold_i  in  THR_W  number of coincident channels required
- trigger_o  out  1  coincidence trigger, registered level

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n_i low):
  - all stretch counters = 0, window register = 0, count register = 0, trigger_o = 0
  - outputs clear immediately (asynchronous); release is synchronous to trig_clk_i.
- Window length:
  - WIN = sum of the 4 fields, 7-bit unsigned, range 0..124, registered once (1-cycle pipeline).
  - WIN = 0 is treated as 1.
  - oneshot_i changes apply to windows loaded afterwards; running windows keep their value.
- Edge detect, per channel:
  - trig_i registered each cycle; a rising edge is trig_i high now and low in the previous cycle.
  - A held-high input gives exactly one edge.
- Stretch, per channel:
  - 7-bit down-counter.
  - On a rising edge with en_i high: load WIN. This also applies while the counter is running (retrigger restarts the full window; windows are not added together).
  - Otherwise, if nonzero: decrement by 1.
  - open[i] = counter != 0.
  - Edge sampled at clock edge k: open is high for exactly WIN cycles, k+1 through k+WIN.
  - en_i low forces the counter to 0 on the next clock and blocks any load.
- Count:
  - popcount of open[NCHAN-1:0], 5-bit (0..24), registered.
- Compare:
  - trigger_o registered; high when count >= threshold_i and threshold_i != 0.
  - threshold_i = 0 disables the trigger (trigger_o stays 0).
  - threshold_i > 24 never fires.
  - threshold_i is compared with zero-extension to 6 bits.
- Latency:
  - A qualifying edge sampled at clock edge k makes trigger_o high from edge k+2.
  - trigger_o stays high while the condition holds and drops 2 cycles after the condition ends.
- Simultaneous events:
  - Several channels rising in the same cycle all count together.
  - A load and an expiry of the same channel in the same cycle: the load wins.
- Threshold or enable change mid-window takes effect on the next compare cycle; no glitch beyond the register boundary.

Decomposition:
- Package radiant_trig_pkg:
  - constants NCHAN=24, NSTAGE=4, STAGE_W=5, THR_W=6
  - WIN_W=7 (sum width), CNT_W=5 (popcount width)
  - typedef win_t = logic [WIN_W-1:0]
- Sub-module radiant_trig_stretch:
  - one channel: edge detect, enable gating, down-counter, open flag
  - instantiated NCHAN times by generate
- Window sum, popcount and compare stay in the top level.

Test Plan:
- Reset:
  - Hold rst_n_i low with trig_i pulsing on all channels -> trigger_o = 0 and all counters 0.
  - Release -> trigger_o still 0 until a new edge arrives.
- Single channel:
  - Set oneshot fields 30,9,0,0 (WIN = 39), en_i = 0x000003, threshold_i = 1.
  - 2-cycle pulse on ch0 at edge k -> trigger_o high from k+2 to k+40 inclusive (39 cycles), then 0.
- Coincidence:
  - Same configuration with threshold_i = 2.
  - ch0 pulse at k, ch1 pulse at k+38 -> trigger_o high at k+40 only.
  - ch1 pulse at k+39 instead -> trigger_o never high.
- Masking:
  - en_i = 0x000001, threshold_i = 1, pulses on ch1..ch23 -> trigger_o stays 0.
  - Clear en_i[0] mid-window -> trigger_o drops 2 cycles after the counter clears.
- Retrigger / held input:
  - ch0 held high for 100 cycles with WIN = 39 -> trigger_o high for exactly 39 cycles.
  - Second ch0 edge at k+20 -> window extended to end at k+20+39 (trigger_o high through k+60).
- Boundaries:
  - threshold_i = 0 with all 24 channels firing -> trigger_o = 0.
  - threshold_i = 24 with all 24 firing together -> trigger_o = 1.
  - threshold_i = 25 -> 0.
  - oneshot fields all 0 -> 1-cycle window.
  - all fields 31 -> 124-cycle window.
